fetch_stage: RTL and testbench

- Instruction-fetch front end. It produces InstrF/PCPlus4F for the F/D pipeline register, and that register consumes them.
- Owns the PC register and a single-outstanding-request instruction-memory port with variable latency.
- Honours stall (StallF) and redirect (RedirectF/PCTargetF) from the hazard/branch logic.
- When no valid instruction is available, it presents a bubble: ValidF=0, InstrF=0.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_stage_pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HAVE,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_BUBBLE = 32'h0;
    localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter with load / increment / hold controls
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Load wins over increment; redirect targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = target_i & ~ADDR_W'(3);
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch FSM and F-stage output registers; FETCH_PERF_CNT_EN adds fetch/stall counters
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              RedirectF,
    input  logic [ADDR_W-1:0] PCTargetF,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       InstrF,
    output logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PCPlus4F,
    output logic              ValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcf_q, pcf_d;
    logic              valid_q, valid_d;
    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] pc;

    pc_reg #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (pc_load),
        .inc_i   (pc_inc),
        .target_i(PCTargetF),
        .pc_o    (pc)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pcf_d    = pcf_q;
        valid_d  = valid_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        imem_req = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (RedirectF) begin
                    pc_load = 1'b1;
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (RedirectF) begin
                    pc_load = 1'b1;
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    pcf_d   = pc;
                    valid_d = 1'b1;
                    state_d = HAVE;
                end
            end
            HAVE: begin
                if (RedirectF) begin
                    valid_d = 1'b0;
                    instr_d = NOP_BUBBLE;
                    pc_load = 1'b1;
                    state_d = REQ;
                end else if (!StallF) begin
                    valid_d = 1'b0;
                    instr_d = NOP_BUBBLE;
                    pc_inc  = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: begin
                // A redirect here only retargets; a response arriving the same
                // cycle is still the stale one, so it retires the drop.
                pc_load = RedirectF;
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            instr_q <= NOP_BUBBLE;
            pcf_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pcf_q   <= pcf_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc;
    assign InstrF    = instr_q;
    assign PCF       = pcf_q;
    assign PCPlus4F  = pcf_q + ADDR_W'(PC_STEP);
    assign ValidF    = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == HAVE) begin
            if (!StallF && !RedirectF) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (StallF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, RedirectF;
    logic [31:0] PCTargetF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        ValidF;

    logic        w_req, w_rvalid, w_valid;
    logic [31:0] w_addr, w_instr, w_pcf, w_pcp4;
    logic        w_zero;
    logic [31:0] w_target;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    int cd  = 0;
    logic [31:0] req_addr = '0;
    logic        w_pend = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .RedirectF(RedirectF),
        .PCTargetF(PCTargetF), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrF(InstrF),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .StallF(w_zero), .RedirectF(w_zero),
        .PCTargetF(w_target), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013), .InstrF(w_instr),
        .PCF(w_pcf), .PCPlus4F(w_pcp4), .ValidF(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(w_fetch_cnt), .stall_cnt(w_stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int max_cycles);
        for (int i = 0; i < max_cycles && !ValidF; i++) tick();
        check("valid_timeout", {31'b0, ValidF}, 32'h1);
    endtask

    // Memory model: response lat cycles after the request, data = base + address.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        w_rvalid    = 1'b0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'h0010_0093 + req_addr;
                end
            end
            if (imem_req) begin
                cd       = lat;
                req_addr = imem_addr;
            end
            w_rvalid = w_pend;
            w_pend   = w_req;
        end
    end

    initial begin
        reset = 1'b1; StallF = 1'b0; RedirectF = 1'b0; PCTargetF = '0;
        w_zero = 1'b0; w_target = '0;
        repeat (2) tick();
        check("rst_valid", {31'b0, ValidF}, 32'h0);
        check("rst_instr", InstrF, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_pcf", PCF, 32'h0);
        check("rst_pcp4", PCPlus4F, 32'h4);
        check("w_rst_pcp4", w_pcp4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        reset = 1'b0;
        tick(); // cycle 1
        check("c1_req", {31'b0, imem_req}, 32'h1);
        check("c1_addr", imem_addr, 32'h0);
        check("w_c1_addr", w_addr, 32'hFFFF_FFFC);
        tick(); // cycle 2
        check("c2_valid", {31'b0, ValidF}, 32'h0);
        tick(); // cycle 3
        check("c3_valid", {31'b0, ValidF}, 32'h1);
        check("c3_instr", InstrF, 32'h0010_0093);
        check("c3_pcf", PCF, 32'h0);
        check("c3_pcp4", PCPlus4F, 32'h4);
        check("w_c3_pcf", w_pcf, 32'hFFFF_FFFC);
        check("w_c3_pcp4", w_pcp4, 32'h0);
        tick(); // cycle 4
        check("c4_addr", imem_addr, 32'h4);
        check("c4_req", {31'b0, imem_req}, 32'h1);
        check("w_c4_req", {31'b0, w_req}, 32'h1);
        check("w_c4_addr", w_addr, 32'h0);

        // Stall five cycles while holding PC 0x8.
        repeat (5) tick(); // cycle 9
        check("c9_pcf", PCF, 32'h8);
        StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'b0, ValidF}, 32'h1);
            check("stall_pcf", PCF, 32'h8);
            check("stall_instr", InstrF, 32'h0010_009B);
            check("stall_req", {31'b0, imem_req}, 32'h0);
        end
        StallF = 1'b0;
        lat = 3;
        tick(); // cycle 15
        check("post_stall_addr", imem_addr, 32'hC);
        check("post_stall_req", {31'b0, imem_req}, 32'h1);
        check("post_stall_instr", InstrF, 32'h0);

        // Redirect one cycle after the request, latency 3.
        tick(); // cycle 16, WAIT
        RedirectF = 1'b1; PCTargetF = 32'h100;
        tick(); // cycle 17, DROP
        RedirectF = 1'b0;
        check("drop_valid17", {31'b0, ValidF}, 32'h0);
        tick();
        check("drop_valid18", {31'b0, ValidF}, 32'h0);
        tick(); // cycle 19
        check("redir_req", {31'b0, imem_req}, 32'h1);
        check("redir_addr", imem_addr, 32'h100);
        wait_valid(10);
        check("redir_pcf", PCF, 32'h100);
        check("redir_instr", InstrF, 32'h0010_0193);

        // Redirect beats stall in HAVE; target low bits are dropped.
        lat = 1;
        StallF = 1'b1; RedirectF = 1'b1; PCTargetF = 32'h203;
        tick();
        StallF = 1'b0; RedirectF = 1'b0;
        check("rs_valid", {31'b0, ValidF}, 32'h0);
        check("rs_instr", InstrF, 32'h0);
        check("rs_addr", imem_addr, 32'h200);
        check("rs_req", {31'b0, imem_req}, 32'h1);
        wait_valid(6);
        check("rs_pcf", PCF, 32'h200);
        check("rs_pcp4", PCPlus4F, 32'h204);
        check("rs_instr2", InstrF, 32'h0010_0293);

        // Reset in WAIT with a late response pending.
        lat = 3;
        tick(); // REQ 0x204
        check("pre_rst_addr", imem_addr, 32'h204);
        tick(); // WAIT
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'b0, ValidF}, 32'h0);
        check("arst_instr", InstrF, 32'h0);
        check("arst_req", {31'b0, imem_req}, 32'h0);
        check("arst_pcf", PCF, 32'h0);
        check("arst_pcp4", PCPlus4F, 32'h4);
        check("arst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_fetch_cnt", fetch_cnt, 32'h0);
        check("arst_stall_cnt", stall_cnt, 32'h0);
`endif
        lat = 1;
        tick();
        reset = 1'b0;
        tick(); // REQ, stale response lands here
        check("late_req", {31'b0, imem_req}, 32'h1);
        check("late_addr", imem_addr, 32'h0);
        tick();
        check("late_valid", {31'b0, ValidF}, 32'h0);
        tick();
        check("late_valid2", {31'b0, ValidF}, 32'h1);
        check("late_pcf", PCF, 32'h0);

        // Redirect in REQ: old response dropped, refetch from target.
        tick(); // REQ 0x4
        RedirectF = 1'b1; PCTargetF = 32'h40;
        tick();
        RedirectF = 1'b0;
        check("rq_valid", {31'b0, ValidF}, 32'h0);
        wait_valid(8);
        check("rq_pcf", PCF, 32'h40);
        check("rq_instr", InstrF, 32'h0010_00D3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
